// File: rtl/lvp_pkg.sv
// Shared types for the load value predictor: FSM states, table/queue entry layouts
// and index/tag geometry helpers. Struct field widths are the predictor's default widths.
package lvp_pkg;

  localparam int LVP_ADDR_W    = 32;
  localparam int LVP_DATA_W    = 32;
  localparam int LVP_TAG_W     = 8;
  localparam int LVP_CONF_BITS = 2;
  localparam int LVP_ID_W      = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPEC    = 2'd1,
    RECOVER = 2'd2
  } lvp_state_e;

  typedef struct packed {
    logic                     valid;
    logic [LVP_TAG_W-1:0]     tag;
    logic [LVP_DATA_W-1:0]    value;
    logic [LVP_CONF_BITS-1:0] conf;
  } lvp_entry_t;

  // use_pred marks a load whose predicted value was actually consumed downstream
  typedef struct packed {
    logic [LVP_ADDR_W-1:0] pc;
    logic [LVP_DATA_W-1:0] value;
    logic                  use_pred;
    logic [LVP_ID_W-1:0]   id;
  } lvp_q_t;

  // Word-aligned PCs: index starts at bit 2, tag sits directly above the index
  function automatic int lvp_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int lvp_tag_lsb(input int entries);
    return $clog2(entries) + 2;
  endfunction

endpackage

// File: rtl/load_value_predictor_spec_queue.sv
// In-order circular FIFO of outstanding speculative loads with push, pop and
// whole-queue flush; the head entry is always visible combinationally.
module lvp_spec_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over everything; a full queue never takes a push even alongside a pop
  assign do_push = push && !flush && (count < CNT_W'(DEPTH));
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/load_value_predictor.sv
// Last-value load predictor with saturating confidence, an in-order speculation
// queue of up to DEPTH loads, and checkpoint recovery on the oldest bad prediction.
module load_value_predictor
  import lvp_pkg::*;
#(
  parameter int ADDR_W      = LVP_ADDR_W,
  parameter int DATA_W      = LVP_DATA_W,
  parameter int ENTRIES     = 64,
  parameter int TAG_W       = LVP_TAG_W,
  parameter int CONF_BITS   = LVP_CONF_BITS,
  parameter int CONF_THRESH = 2,
  parameter int DEPTH       = 4,
  parameter int ID_W        = LVP_ID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              req_ready,
  output logic              pred_valid,
  output logic              pred_use,
  output logic [DATA_W-1:0] pred_data,
  output logic [ID_W-1:0]   pred_id,
  output logic              snap_take,
  output logic [ID_W-1:0]   snap_id,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              mispredict,
  output logic [ID_W-1:0]   recover_id,
  input  logic              recover_done,
  output logic              busy,
  output logic              err_spurious
);

  localparam int IDX_W   = lvp_idx_w(ENTRIES);
  localparam int TAG_LSB = lvp_tag_lsb(ENTRIES);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
  localparam logic [CONF_BITS-1:0] THRESH   = CONF_BITS'(CONF_THRESH);

  lvp_state_e       state_q;
  lvp_state_e       state_d;
  lvp_entry_t       tbl_q [ENTRIES];
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] count;
  lvp_q_t           head;
  lvp_q_t           push_entry;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  lvp_entry_t       req_ent;
  logic             hit_use;
  logic [IDX_W-1:0] head_idx;
  logic [TAG_W-1:0] head_tag;
  lvp_entry_t       head_ent;
  logic             head_match;
  logic             resolving;
  logic             pop;
  logic             spurious;
  logic             mis;
  logic             accept;
  logic             unused_pc_bits;

  assign req_idx = req_pc[TAG_LSB-1:2];
  assign req_tag = req_pc[TAG_LSB+TAG_W-1:TAG_LSB];
  assign req_ent = tbl_q[req_idx];
  assign hit_use = req_ent.valid && (req_ent.tag == req_tag) && (req_ent.conf >= THRESH);

  assign head_idx   = head.pc[TAG_LSB-1:2];
  assign head_tag   = head.pc[TAG_LSB+TAG_W-1:TAG_LSB];
  assign head_ent   = tbl_q[head_idx];
  assign head_match = head_ent.valid && (head_ent.tag == head_tag) && (head_ent.value == res_data);

  // Results are ignored entirely while a recovery is in flight
  assign resolving = res_valid && (state_q != RECOVER);
  assign pop       = resolving && (count != '0);
  assign spurious  = resolving && (count == '0);
  assign mis       = pop && head.use_pred && (head.value != res_data);

  // Ready drops in the mispredict cycle so the flush never races a new push
  assign req_ready = !rst && (count < CNT_W'(DEPTH)) && (state_q != RECOVER) && !mis;
  assign accept    = req_valid && req_ready;
  assign busy      = (count != '0) || (state_q == RECOVER);

  assign push_entry = '{pc: req_pc, value: req_ent.value, use_pred: hit_use, id: id_q};

  assign unused_pc_bits = ^{req_pc[1:0], req_pc[ADDR_W-1:TAG_LSB+TAG_W],
                            head.pc[1:0], head.pc[ADDR_W-1:TAG_LSB+TAG_W]};

  lvp_spec_queue #(
    .W     ($bits(lvp_q_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .flush (mis),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (pop) begin
      if (head_match) begin
        if (head_ent.conf != CONF_MAX) begin
          tbl_q[head_idx].conf <= head_ent.conf + CONF_BITS'(1);
        end
      end else begin
        tbl_q[head_idx] <= '{valid: 1'b1, tag: head_tag, value: res_data, conf: '0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      id_q         <= '0;
      pred_valid   <= 1'b0;
      pred_use     <= 1'b0;
      pred_data    <= '0;
      pred_id      <= '0;
      snap_take    <= 1'b0;
      snap_id      <= '0;
      mispredict   <= 1'b0;
      recover_id   <= '0;
      err_spurious <= 1'b0;
    end else begin
      state_q      <= state_d;
      pred_valid   <= accept;
      pred_use     <= accept && hit_use;
      pred_data    <= (accept && hit_use) ? req_ent.value : '0;
      pred_id      <= accept ? id_q : '0;
      snap_take    <= accept && hit_use;
      snap_id      <= (accept && hit_use) ? id_q : '0;
      mispredict   <= mis;
      recover_id   <= mis ? head.id : '0;
      err_spurious <= spurious;
      if (accept) begin
        id_q <= id_q + ID_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SPEC;
      end
      SPEC: begin
        if (mis) begin
          state_d = RECOVER;
        end else if (pop && !accept && (count == CNT_W'(1))) begin
          state_d = IDLE;
        end
      end
      RECOVER: begin
        if (recover_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_value_predictor.sv
// Directed bench for load_value_predictor: cold miss, training, mispredict flush,
// full queue, spurious result, mid-flight reset, id wrap and confidence saturation.
module tb_load_value_predictor;
  import lvp_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        pred_valid;
  logic        pred_use;
  logic [31:0] pred_data;
  logic [2:0]  pred_id;
  logic        snap_take;
  logic [2:0]  snap_id;
  logic        res_valid;
  logic [31:0] res_data;
  logic        mispredict;
  logic [2:0]  recover_id;
  logic        recover_done;
  logic        busy;
  logic        err_spurious;

  int n_checks;
  int n_pass;

  load_value_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_pc       (req_pc),
    .req_ready    (req_ready),
    .pred_valid   (pred_valid),
    .pred_use     (pred_use),
    .pred_data    (pred_data),
    .pred_id      (pred_id),
    .snap_take    (snap_take),
    .snap_id      (snap_id),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .mispredict   (mispredict),
    .recover_id   (recover_id),
    .recover_done (recover_done),
    .busy         (busy),
    .err_spurious (err_spurious)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drivers: inputs change on negedge, registered outputs are sampled 1 unit after posedge
  task automatic do_req(input logic [31:0] pc);
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = pc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_res(input logic [31:0] d);
    @(negedge clk);
    res_valid = 1'b1;
    res_data  = d;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (pred_valid !== 1'b0) $display("FAIL rst_pred_valid: got %0b want 0", pred_valid); else n_pass++;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %0b want 0", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if ({mispredict, err_spurious, snap_take, pred_use} !== 4'b0) $display("FAIL rst_pulses: got %b want 0000", {mispredict, err_spurious, snap_take, pred_use}); else n_pass++;
    n_checks++; if ({pred_data, pred_id, snap_id, recover_id} !== 41'd0) $display("FAIL rst_values: got %h want 0", {pred_data, pred_id, snap_id, recover_id}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready: got %0b want 1", req_ready); else n_pass++;
    n_checks++; if (dut.state_q !== IDLE) $display("FAIL post_rst_state: got %0d want IDLE", dut.state_q); else n_pass++;
  endtask

  task automatic test_cold_miss();
    do_req(32'h0040_0100);
    n_checks++; if (pred_valid !== 1'b1) $display("FAIL cold_pred_valid: got %0b want 1", pred_valid); else n_pass++;
    n_checks++; if (pred_use !== 1'b0) $display("FAIL cold_pred_use: got %0b want 0", pred_use); else n_pass++;
    n_checks++; if (pred_data !== 32'h0) $display("FAIL cold_pred_data: got %h want 0", pred_data); else n_pass++;
    n_checks++; if (pred_id !== 3'd0) $display("FAIL cold_pred_id: got %0d want 0", pred_id); else n_pass++;
    n_checks++; if (snap_take !== 1'b0) $display("FAIL cold_snap: got %0b want 0", snap_take); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL cold_busy: got %0b want 1", busy); else n_pass++;
    do_res(32'hDEAD_BEEF);
    n_checks++; if (mispredict !== 1'b0) $display("FAIL cold_mispredict: got %0b want 0", mispredict); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL cold_busy_after: got %0b want 0", busy); else n_pass++;
    n_checks++; if (dut.tbl_q[0].value !== 32'hDEAD_BEEF) $display("FAIL cold_tbl_value: got %h want deadbeef", dut.tbl_q[0].value); else n_pass++;
    n_checks++; if (dut.tbl_q[0].conf !== 2'd0) $display("FAIL cold_tbl_conf: got %0d want 0", dut.tbl_q[0].conf); else n_pass++;
    n_checks++; if (dut.tbl_q[0].valid !== 1'b1) $display("FAIL cold_tbl_valid: got %0b want 1", dut.tbl_q[0].valid); else n_pass++;
  endtask

  task automatic test_training();
    logic [2:0] exp_id;
    for (int i = 1; i <= 2; i++) begin
      exp_id = 3'(i);
      do_req(32'h0040_0100);
      n_checks++; if (pred_use !== 1'b0 || pred_id !== exp_id) $display("FAIL train_req%0d: got use=%0b id=%0d want use=0 id=%0d", i, pred_use, pred_id, exp_id); else n_pass++;
      do_res(32'hDEAD_BEEF);
      n_checks++; if (dut.tbl_q[0].conf !== 2'(i)) $display("FAIL train_conf%0d: got %0d want %0d", i, dut.tbl_q[0].conf, i); else n_pass++;
    end
    // Three confident loads stay outstanding for the mispredict scenario
    for (int i = 3; i <= 5; i++) begin
      exp_id = 3'(i);
      do_req(32'h0040_0100);
      n_checks++; if (pred_use !== 1'b1) $display("FAIL conf_use%0d: got %0b want 1", i, pred_use); else n_pass++;
      n_checks++; if (pred_data !== 32'hDEAD_BEEF) $display("FAIL conf_data%0d: got %h want deadbeef", i, pred_data); else n_pass++;
      n_checks++; if (snap_take !== 1'b1 || snap_id !== exp_id || pred_id !== exp_id) $display("FAIL conf_snap%0d: got take=%0b snap_id=%0d pred_id=%0d want 1/%0d/%0d", i, snap_take, snap_id, pred_id, exp_id, exp_id); else n_pass++;
    end
    n_checks++; if (dut.count !== 3'd3) $display("FAIL conf_count: got %0d want 3", dut.count); else n_pass++;
  endtask

  task automatic test_mispredict();
    @(negedge clk);
    res_valid = 1'b1;
    res_data  = 32'h1234_5678;
    req_valid = 1'b1;
    req_pc    = 32'h0040_0100;
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL mis_ready_comb: got %0b want 0", req_ready); else n_pass++;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    req_valid = 1'b0;
    n_checks++; if (mispredict !== 1'b1) $display("FAIL mis_pulse: got %0b want 1", mispredict); else n_pass++;
    n_checks++; if (recover_id !== 3'd3) $display("FAIL mis_recover_id: got %0d want 3", recover_id); else n_pass++;
    n_checks++; if (pred_valid !== 1'b0) $display("FAIL mis_push_dropped: got %0b want 0", pred_valid); else n_pass++;
    n_checks++; if (dut.count !== 3'd0) $display("FAIL mis_flush_count: got %0d want 0", dut.count); else n_pass++;
    n_checks++; if (dut.state_q !== RECOVER) $display("FAIL mis_state: got %0d want RECOVER", dut.state_q); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (mispredict !== 1'b0) $display("FAIL mis_one_cycle: got %0b want 0", mispredict); else n_pass++;
    n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0) $display("FAIL rec_busy_ready: got busy=%0b ready=%0b want 1/0", busy, req_ready); else n_pass++;
    do_res(32'h9999_9999);
    n_checks++; if (err_spurious !== 1'b0 || mispredict !== 1'b0) $display("FAIL rec_res_ignored: got err=%0b mis=%0b want 0/0", err_spurious, mispredict); else n_pass++;
    n_checks++; if (dut.tbl_q[0].value !== 32'h1234_5678 || dut.tbl_q[0].conf !== 2'd0) $display("FAIL mis_tbl: got %h/%0d want 12345678/0", dut.tbl_q[0].value, dut.tbl_q[0].conf); else n_pass++;
    @(negedge clk);
    recover_done = 1'b1;
    @(posedge clk);
    #1;
    recover_done = 1'b0;
    n_checks++; if (dut.state_q !== IDLE) $display("FAIL rec_done_state: got %0d want IDLE", dut.state_q); else n_pass++;
    n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL rec_done_busy_ready: got busy=%0b ready=%0b want 0/1", busy, req_ready); else n_pass++;
  endtask

  task automatic test_full_queue();
    logic [2:0] exp_id;
    for (int i = 0; i < 4; i++) begin
      exp_id = 3'(6 + i);
      do_req(32'h0040_0104);
      n_checks++; if (pred_id !== exp_id || pred_use !== 1'b0) $display("FAIL full_fill%0d: got id=%0d use=%0b want %0d/0", i, pred_id, pred_use, exp_id); else n_pass++;
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = 32'h0040_0104;
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL full_ready: got %0b want 0", req_ready); else n_pass++;
    res_valid = 1'b1;
    res_data  = 32'hA5A5_A5A5;
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL full_no_bypass: got %0b want 0", req_ready); else n_pass++;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    n_checks++; if (pred_valid !== 1'b0 || dut.count !== 3'd3) $display("FAIL full_pop_only: got pv=%0b count=%0d want 0/3", pred_valid, dut.count); else n_pass++;
    @(negedge clk);
    res_valid = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL both_ready: got %0b want 1", req_ready); else n_pass++;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    req_valid = 1'b0;
    n_checks++; if (pred_valid !== 1'b1 || pred_id !== 3'd2) $display("FAIL both_push: got pv=%0b id=%0d want 1/2", pred_valid, pred_id); else n_pass++;
    n_checks++; if (dut.count !== 3'd3) $display("FAIL both_count: got %0d want 3", dut.count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      do_res(32'hA5A5_A5A5);
      n_checks++; if (mispredict !== 1'b0) $display("FAIL full_drain_mis%0d: got %0b want 0", i, mispredict); else n_pass++;
    end
    n_checks++; if (busy !== 1'b0 || dut.state_q !== IDLE) $display("FAIL full_drained: got busy=%0b state=%0d want 0/IDLE", busy, dut.state_q); else n_pass++;
    n_checks++; if (dut.tbl_q[1].conf !== 2'd3) $display("FAIL full_tbl_conf: got %0d want 3", dut.tbl_q[1].conf); else n_pass++;
  endtask

  task automatic test_spurious();
    do_res(32'h5555_5555);
    n_checks++; if (err_spurious !== 1'b1) $display("FAIL spur_pulse: got %0b want 1", err_spurious); else n_pass++;
    n_checks++; if (mispredict !== 1'b0 || busy !== 1'b0) $display("FAIL spur_side: got mis=%0b busy=%0b want 0/0", mispredict, busy); else n_pass++;
    n_checks++; if (dut.tbl_q[1].value !== 32'hA5A5_A5A5 || dut.tbl_q[1].conf !== 2'd3) $display("FAIL spur_tbl: got %h/%0d want a5a5a5a5/3", dut.tbl_q[1].value, dut.tbl_q[1].conf); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (err_spurious !== 1'b0) $display("FAIL spur_one_cycle: got %0b want 0", err_spurious); else n_pass++;
  endtask

  task automatic test_reset_mid_spec();
    do_req(32'h0040_0104);
    n_checks++; if (pred_use !== 1'b1 || pred_data !== 32'hA5A5_A5A5 || pred_id !== 3'd3) $display("FAIL pre_rst_pred: got use=%0b data=%h id=%0d want 1/a5a5a5a5/3", pred_use, pred_data, pred_id); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if ({pred_valid, pred_use, snap_take, busy, req_ready} !== 5'b0) $display("FAIL mid_rst_flags: got %b want 00000", {pred_valid, pred_use, snap_take, busy, req_ready}); else n_pass++;
    n_checks++; if ({pred_data, pred_id, snap_id} !== 38'd0) $display("FAIL mid_rst_values: got %h want 0", {pred_data, pred_id, snap_id}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    do_req(32'h0040_0104);
    n_checks++; if (pred_valid !== 1'b1 || pred_use !== 1'b0 || pred_data !== 32'h0 || pred_id !== 3'd0) $display("FAIL post_rst_pred: got pv=%0b use=%0b data=%h id=%0d want 1/0/0/0", pred_valid, pred_use, pred_data, pred_id); else n_pass++;
    do_res(32'hA5A5_A5A5);
    n_checks++; if (mispredict !== 1'b0 || busy !== 1'b0) $display("FAIL post_rst_res: got mis=%0b busy=%0b want 0/0", mispredict, busy); else n_pass++;
  endtask

  task automatic test_id_wrap_saturation();
    logic [2:0] exp_id;
    logic [1:0] exp_conf;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      exp_id   = 3'(i);
      exp_conf = (i > 3) ? 2'd3 : 2'(i);
      do_req(32'h0040_0108);
      n_checks++; if (pred_id !== exp_id) $display("FAIL wrap_id%0d: got %0d want %0d", i, pred_id, exp_id); else n_pass++;
      n_checks++; if (pred_use !== (i >= 3)) $display("FAIL wrap_use%0d: got %0b want %0b", i, pred_use, (i >= 3)); else n_pass++;
      do_res(32'hCAFE_F00D);
      n_checks++; if (dut.tbl_q[2].conf !== exp_conf) $display("FAIL sat_conf%0d: got %0d want %0d", i, dut.tbl_q[2].conf, exp_conf); else n_pass++;
      n_checks++; if (mispredict !== 1'b0) $display("FAIL wrap_mis%0d: got %0b want 0", i, mispredict); else n_pass++;
    end
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_pc       = '0;
    res_valid    = 1'b0;
    res_data     = '0;
    recover_done = 1'b0;
    test_reset();
    test_cold_miss();
    test_training();
    test_mispredict();
    test_full_queue();
    test_spurious();
    test_reset_mid_spec();
    test_id_wrap_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
